// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared helpers for the dual-clock Gray-pointer FIFO.
//   addr_w_of : address width for a given entry count
//   is_pow2   : depth legality test used at elaboration
//   bin2gray  : binary-to-reflected-Gray conversion (up to 32 bits)
package async_fifo_pkg;

  function automatic int addr_w_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a Gray-coded bus entering clk's domain.
//   clk   : destination-domain clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : bus from the source domain (must change at most one bit at a time)
//   q     : synchronized copy, two clk edges behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/async_gray_fifo.sv
// async_gray_fifo: dual-clock FIFO moving RAM_WIDTH-bit words from wr_clk to
// rd_clk using binary/Gray pointers and two-flop pointer synchronizers.
//   rst_n      : asynchronous active-low reset for both domains
//   wr_clk     : write-domain clock
//   wr_en      : write request (wr_clk)
//   wr_data    : write word, taken with wr_en
//   fifo_full  : wr_clk domain, no free entry
//   rd_clk     : read-domain clock, unrelated to wr_clk
//   rd_en      : read request (rd_clk)
//   rd_data    : registered read word (rd_clk)
//   fifo_empty : rd_clk domain, no readable entry
//
// Handshake: a write is accepted on a wr_clk edge where wr_en=1 and
// fifo_full=0; a read is accepted on an rd_clk edge where rd_en=1 and
// fifo_empty=0. Requests made while the flag is set are dropped with no side
// effect, so the producer/consumer may hold their request high freely.
module async_gray_fifo
  import async_fifo_pkg::*;
#(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 256
) (
  input  logic                 rst_n,
  input  logic                 wr_clk,
  input  logic                 rd_clk,
  input  logic                 wr_en,
  input  logic [RAM_WIDTH-1:0] wr_data,
  output logic                 fifo_full,
  input  logic                 rd_en,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic                 fifo_empty
);

  localparam int ADDR_W = addr_w_of(RAM_DEPTH);
  localparam int PW     = ADDR_W + 1;

  if (!is_pow2(RAM_DEPTH) || RAM_DEPTH < 4) begin : g_bad_depth
    $error("async_gray_fifo: RAM_DEPTH must be a power of two and >= 4");
  end

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wr_bin, wr_bin_next, wr_gray, wr_gray_next;
  logic [PW-1:0] rq2, full_ref;
  logic          wr_accept;

  assign wr_accept    = wr_en && !fifo_full;
  assign wr_bin_next  = wr_bin + PW'(wr_accept);
  assign wr_gray_next = PW'(bin2gray(32'(wr_bin_next)));
  // Full when the write pointer is exactly one lap ahead of the read pointer;
  // in Gray code that means the top two bits differ and the rest match.
  assign full_ref     = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin    <= '0;
      wr_gray   <= '0;
      fifo_full <= 1'b0;
    end else begin
      wr_bin    <= wr_bin_next;
      wr_gray   <= wr_gray_next;
      fifo_full <= (wr_gray_next == full_ref);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_accept) begin
      mem[wr_bin[ADDR_W-1:0]] <= wr_data;
    end
  end

  // ---------------- read domain ----------------
  logic [PW-1:0] rd_bin, rd_bin_next, rd_gray, rd_gray_next;
  logic [PW-1:0] wq2;
  logic          rd_accept;

  assign rd_accept    = rd_en && !fifo_empty;
  assign rd_bin_next  = rd_bin + PW'(rd_accept);
  assign rd_gray_next = PW'(bin2gray(32'(rd_bin_next)));

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bin     <= '0;
      rd_gray    <= '0;
      fifo_empty <= 1'b1;
    end else begin
      rd_bin     <= rd_bin_next;
      rd_gray    <= rd_gray_next;
      fifo_empty <= (rd_gray_next == wq2);
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_accept) begin
      rd_data <= mem[rd_bin[ADDR_W-1:0]];
    end
  end

  // ---------------- pointer crossings (Gray only) ----------------
  sync_2ff #(.WIDTH(PW)) u_sync_wr2rd (
    .clk   (rd_clk),
    .rst_n (rst_n),
    .d     (wr_gray),
    .q     (wq2)
  );

  sync_2ff #(.WIDTH(PW)) u_sync_rd2wr (
    .clk   (wr_clk),
    .rst_n (rst_n),
    .d     (rd_gray),
    .q     (rq2)
  );

endmodule

// File: tb/tb_async_gray_fifo.sv
// tb_async_gray_fifo: directed bench for async_gray_fifo at default parameters
// (16-bit words, 256 entries). wr_clk 20 ns, rd_clk 60 ns with a phase offset
// so the two clocks never share an edge.
module tb_async_gray_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic rst_n = 1'b0;
  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] rd_data;
  logic fifo_full;
  logic fifo_empty;

  always #10 wr_clk = ~wr_clk;
  initial begin
    #7;
    forever #30 rd_clk = ~rd_clk;
  end

  async_gray_fifo #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH)) dut (
    .rst_n      (rst_n),
    .wr_clk     (wr_clk),
    .rd_clk     (rd_clk),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Single write on the next wr_clk edge; returns aligned 1 ns after that edge.
  task automatic write_one(input logic [W-1:0] d);
    @(posedge wr_clk); #1;
    wr_en = 1'b1;
    wr_data = d;
    @(posedge wr_clk); #1;
    wr_en = 1'b0;
  endtask

  // Waits at most 3 rd_clk edges for fifo_empty to fall, then checks it.
  task automatic wait_not_empty(input string name);
    int n;
    n = 0;
    while (fifo_empty && n < 3) begin
      @(posedge rd_clk); #1;
      n++;
    end
    check(name, 32'(fifo_empty), 32'd0);
  endtask

  // Single read on the next rd_clk edge, then checks data and empty flag.
  task automatic read_one(input string name, input logic [W-1:0] exp, input logic exp_empty);
    @(posedge rd_clk); #1;
    rd_en = 1'b1;
    @(posedge rd_clk); #1;
    rd_en = 1'b0;
    check({name, "_data"}, 32'(rd_data), 32'(exp));
    check({name, "_empty"}, 32'(fifo_empty), 32'(exp_empty));
  endtask

  // ---------------- single-word vectors ----------------
  typedef struct {
    logic [W-1:0] wdata;
    logic [W-1:0] exp_data;
    logic         exp_empty;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int got;
    int cyc;
    int n;
    int nreads;
    bit first;
    bit was_empty;
    bit will_accept;
    bit wr_done;
    logic [W-1:0] e;

    vecs[0] = '{16'hA5A5, 16'hA5A5, 1'b1};
    vecs[1] = '{16'h0000, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h5A5A, 16'h5A5A, 1'b1};
    vecs[4] = '{16'h8001, 16'h8001, 1'b1};
    vecs[5] = '{16'h0100, 16'h0100, 1'b1};

    // Reset for 200 ns.
    rst_n = 1'b0;
    #200;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge wr_clk); #5;
    rst_n = 1'b1;

    // Toggling rd_en while empty must not disturb rd_data.
    @(posedge rd_clk); #1;
    for (int i = 0; i < 4; i++) begin
      rd_en = ~rd_en;
      @(posedge rd_clk); #1;
      check("idle_rd_data", 32'(rd_data), 32'd0);
      check("idle_empty", 32'(fifo_empty), 32'd1);
    end
    rd_en = 1'b0;

    // Fill: write 0..299 every wr_clk; full rises on the edge taking word 255.
    @(posedge wr_clk); #1;
    for (int i = 0; i < 300; i++) begin
      wr_en = 1'b1;
      wr_data = W'(i);
      @(posedge wr_clk); #1;
      check("fill_full", 32'(fifo_full), 32'(i >= DEPTH - 1));
    end
    wr_en = 1'b0;

    // Drain with rd_en held high: exactly 0..255, then rd_data holds.
    @(posedge rd_clk); #1;
    rd_en = 1'b1;
    got = 0;
    cyc = 0;
    first = 1'b1;
    while (got < DEPTH && cyc < 600) begin
      was_empty = fifo_empty;
      @(posedge rd_clk); #1;
      cyc++;
      if (!was_empty) begin
        check("drain_data", 32'(rd_data), 32'(got));
        check("drain_empty", 32'(fifo_empty), 32'(got == DEPTH - 1));
        got++;
        if (first) begin
          first = 1'b0;
          n = 0;
          while (fifo_full && n < 3) begin
            @(posedge wr_clk); #1;
            n++;
          end
          check("drain_full_fall", 32'(fifo_full), 32'd0);
        end
      end
    end
    check("drain_count", 32'(got), 32'(DEPTH));
    for (int i = 0; i < 3; i++) begin
      @(posedge rd_clk); #1;
      check("drain_hold_data", 32'(rd_data), 32'(DEPTH - 1));
      check("drain_hold_empty", 32'(fifo_empty), 32'd1);
    end
    rd_en = 1'b0;

    // Concurrent streaming: random writes, continuous reads, several wraps.
    wr_done = 1'b0;
    nreads = 0;
    fork
      begin
        @(posedge wr_clk); #1;
        for (int i = 0; i < 2600; i++) begin
          wr_en = 1'($urandom_range(0, 1));
          wr_data = W'($urandom_range(0, 65535));
          will_accept = wr_en && !fifo_full;
          @(posedge wr_clk);
          if (will_accept) exp_q.push_back(wr_data);
          #1;
        end
        wr_en = 1'b0;
        wr_done = 1'b1;
      end
      begin
        int rcyc;
        bit re;
        rcyc = 0;
        @(posedge rd_clk); #1;
        rd_en = 1'b1;
        while ((!wr_done || exp_q.size() != 0) && rcyc < 5000) begin
          re = fifo_empty;
          @(posedge rd_clk); #1;
          rcyc++;
          if (!re) begin
            if (exp_q.size() == 0) begin
              check("stream_underflow", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("stream_data", 32'(rd_data), 32'(e));
              nreads++;
            end
          end
        end
        rd_en = 1'b0;
      end
    join
    check("stream_leftover", 32'(exp_q.size()), 32'd0);
    check("stream_wraps", 32'(nreads >= 3 * DEPTH), 32'd1);
    check("stream_end_empty", 32'(fifo_empty), 32'd1);

    // Single-word vectors: write, empty falls within 3 rd edges, read back.
    for (int v = 0; v < 6; v++) begin
      write_one(vecs[v].wdata);
      wait_not_empty("single_empty_fall");
      read_one("single", vecs[v].exp_data, vecs[v].exp_empty);
    end

    // Mid-stream reset with 100 words queued.
    @(posedge wr_clk); #1;
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1;
      wr_data = W'(16'h1000 + i);
      @(posedge wr_clk); #1;
    end
    wr_en = 1'b0;
    check("mid_full_before", 32'(fifo_full), 32'd0);
    repeat (4) @(posedge rd_clk);
    #1;
    check("mid_empty_before", 32'(fifo_empty), 32'd0);
    @(posedge wr_clk); #5;
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 32'(fifo_empty), 32'd1);
    check("mid_rst_full", 32'(fifo_full), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    #100;
    @(posedge wr_clk); #5;
    rst_n = 1'b1;
    write_one(16'hBEEF);
    wait_not_empty("mid_empty_fall");
    read_one("mid_first", 16'hBEEF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
